quote_scheduler: RTL and testbench
==================================

QUOTE_SCHEDULER -- requirements
Module: quote_scheduler

Interface
REQ-001 Parameters SHALL be: NUM_STOCKS, default 4, number of stocks (power of 2); DATA_WIDTH, default 32, price width; QTY_WIDTH, default 33, quantity width; MIN_GAP, default 8, per-stock cycles between issued quotes.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- i_clk  in  1  single clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_quote_valid  in  1  new quote from trading logic this cycle
- i_stock_id  in  $clog2(NUM_STOCKS)  stock of incoming quote
- i_buy_price  in  DATA_WIDTH  bid quote
- i_sell_price  in  DATA_WIDTH  ask quote
- i_quantity  in  QTY_WIDTH  filtered order quantity
- i_book_is_busy  in  1  order book busy; no issue while high
- i_out_ready  in  1  downstream reverse parser accepts quote
- o_quote_valid  out  1  quote presented downstream
- o_stock_id  out  $clog2(NUM_STOCKS)  stock of presented quote
- o_buy_price  out  DATA_WIDTH  presented bid
- o_sell_price  out  DATA_WIDTH  presented ask
- o_quantity  out  QTY_WIDTH  presented quantity
- o_pending  out  NUM_STOCKS  per-stock slot-occupied flags
- o_drop_count  out  16  quotes overwritten before issue, saturating

Function
REQ-003 Each stock SHALL own one slot (buy, sell, quantity, pending flag); i_quote_valid writes slot[i_stock_id] and sets pending at the next edge.
REQ-004 A write to an already-pending slot SHALL overwrite it (latest wins) and increment o_drop_count, saturating at 16'hFFFF.
REQ-005 FSM SHALL have states IDLE and SEND.
REQ-006 IDLE->SEND SHALL occur when i_book_is_busy is low and at least one slot is eligible (pending and throttle counter zero); the winner's contents are copied into output registers and o_quote_valid rises on the next cycle.
REQ-007 Arbitration SHALL be round-robin: search starts at rr_ptr, first eligible index (ascending, modulo NUM_STOCKS) wins.
REQ-008 In SEND, outputs SHALL hold stable until i_out_ready is high; on that edge: o_quote_valid falls, winner's pending clears, winner's throttle loads MIN_GAP, rr_ptr becomes winner+1 mod NUM_STOCKS, state returns to IDLE.
REQ-009 A write to the winner's slot while in SEND or on the handshake edge SHALL not alter the presented quote; the slot stays pending with the new data, no drop counted.
REQ-010 i_book_is_busy rising during SEND SHALL NOT revoke the presented quote.
REQ-011 Throttle counters SHALL decrement by 1 per cycle while non-zero, independently per stock.
REQ-012 Minimum latency SHALL be 2 cycles: write at edge N, o_quote_valid high after edge N+1.
REQ-013 At most one quote SHALL be issued per 2 cycles (IDLE cycle between consecutive quotes).
REQ-014 o_pending SHALL reflect the registered pending flags directly.

Reset
REQ-015 While i_reset is high at an edge: state IDLE, o_quote_valid 0, all data outputs 0, all pending flags 0, all throttle counters 0, rr_ptr 0, o_drop_count 0.
REQ-016 Reset during SEND SHALL drop the presented quote; no handshake is recorded.
REQ-017 Inputs during reset SHALL be ignored; i_quote_valid in the first cycle after reset deassertion SHALL be accepted.

Configuration
REQ-018 Macro QUOTE_SCHED_THROTTLE_EN defined: per-stock MIN_GAP throttle as REQ-006/008/011.
REQ-019 Macro QUOTE_SCHED_THROTTLE_EN undefined: no throttle counters; eligibility = pending only; MIN_GAP unused.

Verification
REQ-020 Single quote stock 2 (buy 100, sell 102, qty 5), i_out_ready=1 -> o_quote_valid 2 cycles later with identical fields, asserted 1 cycle, o_pending=0 after.
REQ-021 Quotes for stocks 0,1,2,3 same cycle range, ready=1 -> issued in order 0,1,2,3; rr_ptr wraps to 0.
REQ-022 Two writes to stock 1 (buy 10, then buy 11) while i_book_is_busy=1 -> busy released: single quote buy 11, o_drop_count=1.
REQ-023 i_out_ready=0 for 5 cycles in SEND while stock 0 rewritten to buy 50 -> original fields held stable; after ready, second quote buy 50 issued no earlier than MIN_GAP=8 cycles later (THROTTLE_EN) or 2 cycles later (no macro).
REQ-024 i_reset=1 mid-SEND -> next cycle o_quote_valid=0, o_pending=0, o_drop_count=0.
REQ-025 Drop counter driven by 70000 overwrites -> o_drop_count=16'hFFFF, no wrap.

Source files
------------

// File: rtl/quote_scheduler.sv
// Per-stock quote slots with round-robin issue to a ready/valid downstream port.
// Optional per-stock issue throttle enabled by defining QUOTE_SCHED_THROTTLE_EN.
module quote_scheduler #(
    parameter int NUM_STOCKS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int QTY_WIDTH  = 33,
    parameter int MIN_GAP    = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_quote_valid,
    input  logic [$clog2(NUM_STOCKS)-1:0] i_stock_id,
    input  logic [DATA_WIDTH-1:0]         i_buy_price,
    input  logic [DATA_WIDTH-1:0]         i_sell_price,
    input  logic [QTY_WIDTH-1:0]          i_quantity,
    input  logic                          i_book_is_busy,
    input  logic                          i_out_ready,
    output logic                          o_quote_valid,
    output logic [$clog2(NUM_STOCKS)-1:0] o_stock_id,
    output logic [DATA_WIDTH-1:0]         o_buy_price,
    output logic [DATA_WIDTH-1:0]         o_sell_price,
    output logic [QTY_WIDTH-1:0]          o_quantity,
    output logic [NUM_STOCKS-1:0]         o_pending,
    output logic [15:0]                   o_drop_count
);
    localparam int IW = $clog2(NUM_STOCKS);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    if (MIN_GAP < 0 || NUM_STOCKS < 2 || (NUM_STOCKS & (NUM_STOCKS - 1)) != 0) begin : g_param_check
        $error("quote_scheduler: NUM_STOCKS must be a power of 2 >= 2 and MIN_GAP >= 0");
    end

    logic [DATA_WIDTH-1:0] buy_r  [NUM_STOCKS];
    logic [DATA_WIDTH-1:0] sell_r [NUM_STOCKS];
    logic [QTY_WIDTH-1:0]  qty_r  [NUM_STOCKS];
    logic [NUM_STOCKS-1:0] pending_r;
    logic [0:0]            state_r;
    logic [IW-1:0]         winner_r;
    logic [IW-1:0]         rr_ptr_r;
    logic                  dirty_r;
    logic [15:0]           drop_count_r;

    logic [NUM_STOCKS-1:0] eligible_s;
    logic [IW-1:0]         cand_s;
    logic [IW-1:0]         grant_s;
    logic                  grant_found_s;
    logic                  issue_s;
    logic                  handshake_s;
    logic                  wr_in_flight_s;
    logic                  drop_s;

`ifdef QUOTE_SCHED_THROTTLE_EN
    localparam int TW = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;
    logic [TW-1:0] throttle_r [NUM_STOCKS];

    // Eligibility: pending and out of its post-issue quiet period
    always_comb begin
        eligible_s = {NUM_STOCKS{1'b0}};
        for (int s = 0; s < NUM_STOCKS; s++) begin
            eligible_s[s] = pending_r[s] && (throttle_r[s] == {TW{1'b0}});
        end
    end

    // Throttle counters: reload on handshake, count down to zero
    always_ff @(posedge i_clk) begin
        for (int s = 0; s < NUM_STOCKS; s++) begin
            if (i_reset) begin
                throttle_r[s] <= {TW{1'b0}};
            end else if (handshake_s && winner_r == IW'(s)) begin
                throttle_r[s] <= TW'(MIN_GAP);
            end else if (throttle_r[s] != {TW{1'b0}}) begin
                throttle_r[s] <= throttle_r[s] - 1'b1;
            end else begin
                throttle_r[s] <= throttle_r[s];
            end
        end
    end
`else
    assign eligible_s = pending_r;
`endif

    // Round-robin search starting at rr_ptr_r
    always_comb begin
        grant_found_s = 1'b0;
        grant_s       = rr_ptr_r;
        cand_s        = rr_ptr_r;
        for (int k = 0; k < NUM_STOCKS; k++) begin
            cand_s        = rr_ptr_r + IW'(k);
            grant_s       = (!grant_found_s && eligible_s[cand_s]) ? cand_s : grant_s;
            grant_found_s = grant_found_s | eligible_s[cand_s];
        end
    end

    // A write into the quote being issued/presented is not a drop unless it replaces an earlier unissued rewrite
    always_comb begin
        issue_s        = (state_r == ST_IDLE) && !i_book_is_busy && grant_found_s;
        handshake_s    = (state_r == ST_SEND) && i_out_ready;
        wr_in_flight_s = i_quote_valid &&
                         (((state_r == ST_SEND) && (i_stock_id == winner_r)) ||
                          (issue_s && (i_stock_id == grant_s)));
        drop_s         = i_quote_valid && pending_r[i_stock_id] &&
                         (!wr_in_flight_s || ((state_r == ST_SEND) && dirty_r));
    end

    // Slot storage and pending flags
    always_ff @(posedge i_clk) begin
        for (int s = 0; s < NUM_STOCKS; s++) begin
            if (i_reset) begin
                buy_r[s]     <= {DATA_WIDTH{1'b0}};
                sell_r[s]    <= {DATA_WIDTH{1'b0}};
                qty_r[s]     <= {QTY_WIDTH{1'b0}};
                pending_r[s] <= 1'b0;
            end else if (i_quote_valid && i_stock_id == IW'(s)) begin
                buy_r[s]     <= i_buy_price;
                sell_r[s]    <= i_sell_price;
                qty_r[s]     <= i_quantity;
                pending_r[s] <= 1'b1;
            end else if (handshake_s && winner_r == IW'(s) && !dirty_r) begin
                pending_r[s] <= 1'b0;
            end else begin
                pending_r[s] <= pending_r[s];
            end
        end
    end

    // Issue FSM and presented-quote registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r       <= ST_IDLE;
            winner_r      <= {IW{1'b0}};
            rr_ptr_r      <= {IW{1'b0}};
            dirty_r       <= 1'b0;
            o_quote_valid <= 1'b0;
            o_stock_id    <= {IW{1'b0}};
            o_buy_price   <= {DATA_WIDTH{1'b0}};
            o_sell_price  <= {DATA_WIDTH{1'b0}};
            o_quantity    <= {QTY_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (issue_s) begin
                        state_r       <= ST_SEND;
                        winner_r      <= grant_s;
                        dirty_r       <= wr_in_flight_s;
                        o_quote_valid <= 1'b1;
                        o_stock_id    <= grant_s;
                        o_buy_price   <= buy_r[grant_s];
                        o_sell_price  <= sell_r[grant_s];
                        o_quantity    <= qty_r[grant_s];
                    end else begin
                        o_quote_valid <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (handshake_s) begin
                        state_r       <= ST_IDLE;
                        rr_ptr_r      <= winner_r + 1'b1;
                        dirty_r       <= 1'b0;
                        o_quote_valid <= 1'b0;
                    end else begin
                        dirty_r       <= dirty_r | wr_in_flight_s;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    dirty_r       <= 1'b0;
                    o_quote_valid <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of overwritten, never-issued quotes
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            drop_count_r <= 16'd0;
        end else if (drop_s && drop_count_r != 16'hFFFF) begin
            drop_count_r <= drop_count_r + 16'd1;
        end else begin
            drop_count_r <= drop_count_r;
        end
    end

    assign o_pending    = pending_r;
    assign o_drop_count = drop_count_r;

endmodule

// File: tb/tb_quote_scheduler.sv
// Directed bench for quote_scheduler: table of single-quote transactions plus
// hand-written sequences for arbitration, overwrite, backpressure and reset.
module tb_quote_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        qv;
    logic [1:0]  sid;
    logic [31:0] buy, sell;
    logic [32:0] qty;
    logic        busy, ready;
    logic        o_qv;
    logic [1:0]  o_sid;
    logic [31:0] o_buy, o_sell;
    logic [32:0] o_qty;
    logic [3:0]  o_pend;
    logic [15:0] o_drop;

    int n_cmp = 0;
    int n_fail = 0;

    quote_scheduler dut (
        .i_clk(clk), .i_reset(rst), .i_quote_valid(qv), .i_stock_id(sid),
        .i_buy_price(buy), .i_sell_price(sell), .i_quantity(qty),
        .i_book_is_busy(busy), .i_out_ready(ready),
        .o_quote_valid(o_qv), .o_stock_id(o_sid), .o_buy_price(o_buy),
        .o_sell_price(o_sell), .o_quantity(o_qty), .o_pending(o_pend),
        .o_drop_count(o_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  stock;
        logic [31:0] buy;
        logic [31:0] sell;
        logic [32:0] qty;
        logic [3:0]  exp_pend;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (o_qv) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; qv = 1'b0; busy = 1'b0; ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic write(input logic [1:0] s, input logic [31:0] b);
        qv = 1'b1; sid = s; buy = b; sell = b + 32'd1; qty = 33'd1;
        tick();
        qv = 1'b0;
    endtask

    int n;
    int seen[$];

    initial begin
        vecs[0] = '{stock: 2'd2, buy: 32'd100,        sell: 32'd102,        qty: 33'd5,           exp_pend: 4'b0100};
        vecs[1] = '{stock: 2'd0, buy: 32'h0000_0001,  sell: 32'h8000_0000,  qty: 33'h0_0000_0000, exp_pend: 4'b0001};
        vecs[2] = '{stock: 2'd3, buy: 32'hFFFF_FFFF,  sell: 32'hFFFF_FFFE,  qty: 33'h1_FFFF_FFFF, exp_pend: 4'b1000};
        vecs[3] = '{stock: 2'd1, buy: 32'h1234_5678,  sell: 32'h9ABC_DEF0,  qty: 33'h1_0000_0000, exp_pend: 4'b0010};

        rst = 1'b1; qv = 1'b0; sid = 2'd0; buy = 32'd0; sell = 32'd0; qty = 33'd0;
        busy = 1'b0; ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_valid", 64'(o_qv), 64'd0);
        chk("reset_pending", 64'(o_pend), 64'd0);
        chk("reset_drop", 64'(o_drop), 64'd0);
        chk("reset_buy", 64'(o_buy), 64'd0);
        chk("reset_qty", 64'(o_qty), 64'd0);

        // Single quotes: write, valid two edges later for one cycle, slot empties
        for (int v = 0; v < 4; v++) begin
            qv = 1'b1; sid = vecs[v].stock; buy = vecs[v].buy; sell = vecs[v].sell; qty = vecs[v].qty;
            tick();
            qv = 1'b0;
            chk("vec_valid_lat1", 64'(o_qv), 64'd0);
            chk("vec_pend_set", 64'(o_pend), 64'(vecs[v].exp_pend));
            tick();
            chk("vec_valid", 64'(o_qv), 64'd1);
            chk("vec_stock", 64'(o_sid), 64'(vecs[v].stock));
            chk("vec_buy", 64'(o_buy), 64'(vecs[v].buy));
            chk("vec_sell", 64'(o_sell), 64'(vecs[v].sell));
            chk("vec_qty", 64'(o_qty), 64'(vecs[v].qty));
            tick();
            chk("vec_valid_drop", 64'(o_qv), 64'd0);
            chk("vec_pend_clr", 64'(o_pend), 64'd0);
            tick();
        end

        // Round robin over all four stocks, then pointer wraps to 0
        do_reset();
        busy = 1'b1;
        write(2'd3, 32'd30); write(2'd1, 32'd10); write(2'd0, 32'd0); write(2'd2, 32'd20);
        chk("rr_all_pending", 64'(o_pend), 64'hF);
        busy = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (o_qv) seen.push_back(int'(o_sid));
        end
        chk("rr_count", 64'(seen.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("rr_order", 64'((i < seen.size()) ? seen[i] : -1), 64'(i));
        end
        chk("rr_pend_empty", 64'(o_pend), 64'd0);
        busy = 1'b1;
        write(2'd3, 32'd33); write(2'd0, 32'd44);
        busy = 1'b0;
        wait_valid(20, n);
        chk("rr_wrap_timeout", 64'(n > 0), 64'd1);
        chk("rr_wrap_first", 64'(o_sid), 64'd0);
        tick();
        wait_valid(20, n);
        chk("rr_wrap_second", 64'(o_sid), 64'd3);

        // Overwrite while book busy: latest wins, one drop
        do_reset();
        busy = 1'b1;
        write(2'd1, 32'd10);
        write(2'd1, 32'd11);
        chk("ovw_drop", 64'(o_drop), 64'd1);
        tick();
        chk("ovw_busy_holds", 64'(o_qv), 64'd0);
        busy = 1'b0;
        wait_valid(10, n);
        chk("ovw_latency", 64'(n), 64'd1);
        chk("ovw_buy", 64'(o_buy), 64'd11);
        tick();
        wait_valid(15, n);
        chk("ovw_single", 64'(n), 64'hFFFF_FFFF_FFFF_FFFF);

        // Backpressure with rewrite of the presented stock
        do_reset();
        ready = 1'b0;
        qv = 1'b1; sid = 2'd0; buy = 32'd20; sell = 32'd21; qty = 33'd3;
        tick();
        qv = 1'b0;
        tick();
        chk("bp_valid", 64'(o_qv), 64'd1);
        qv = 1'b1; sid = 2'd0; buy = 32'd50; sell = 32'd51; qty = 33'd4;
        for (int i = 0; i < 5; i++) begin
            tick();
            qv = 1'b0;
            chk("bp_hold_valid", 64'(o_qv), 64'd1);
            chk("bp_hold_buy", 64'(o_buy), 64'd20);
            chk("bp_hold_qty", 64'(o_qty), 64'd3);
        end
        chk("bp_no_drop", 64'(o_drop), 64'd0);
        ready = 1'b1;
        tick();
        chk("bp_hs_valid", 64'(o_qv), 64'd0);
        chk("bp_still_pending", 64'(o_pend), 64'b0001);
        wait_valid(20, n);
`ifdef QUOTE_SCHED_THROTTLE_EN
        chk("bp_gap", 64'(n), 64'd9);
`else
        chk("bp_gap", 64'(n), 64'd1);
`endif
        chk("bp_second_buy", 64'(o_buy), 64'd50);
        tick();
        chk("bp_final_pend", 64'(o_pend), 64'd0);

        // Reset in SEND, inputs ignored during reset, first post-reset write accepted
        do_reset();
        busy = 1'b1;
        write(2'd0, 32'd1); write(2'd0, 32'd2); write(2'd1, 32'd9);
        busy = 1'b0; ready = 1'b0;
        wait_valid(10, n);
        chk("rst_pre_buy", 64'(o_buy), 64'd2);
        chk("rst_pre_drop", 64'(o_drop), 64'd1);
        rst = 1'b1; qv = 1'b1; sid = 2'd3; buy = 32'd99;
        tick();
        rst = 1'b0;
        chk("rst_valid", 64'(o_qv), 64'd0);
        chk("rst_pend", 64'(o_pend), 64'd0);
        chk("rst_drop", 64'(o_drop), 64'd0);
        chk("rst_buy", 64'(o_buy), 64'd0);
        sid = 2'd2; buy = 32'd7;
        tick();
        qv = 1'b0; ready = 1'b1;
        chk("rst_first_write", 64'(o_pend), 64'b0100);
        tick();
        chk("rst_issue_valid", 64'(o_qv), 64'd1);
        chk("rst_issue_stock", 64'(o_sid), 64'd2);
        chk("rst_issue_buy", 64'(o_buy), 64'd7);

        // Drop counter saturation
        do_reset();
        busy = 1'b1; qv = 1'b1; sid = 2'd0; buy = 32'd5;
        for (int i = 1; i <= 70001; i++) begin
            tick();
            if (i == 65535) chk("sat_before", 64'(o_drop), 64'hFFFE);
            if (i == 65536) chk("sat_reach", 64'(o_drop), 64'hFFFF);
        end
        qv = 1'b0;
        chk("sat_hold", 64'(o_drop), 64'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
